int_mul_iter: RTL

- Iterative multi-cycle integer multiplier for the River execute stage; the arithmetic counterpart of the integer divider.
- Executes RV64M MUL/MULH/MULHSU/MULHU and RV32 MULW with a fixed, operand-independent latency.
- Sits beside the divider in the ALU dispatch path.
- Uses the same handshake as the divider: enable pulse in, busy level, one-cycle valid out.

---
 rtl/int_mul_iter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/int_mul_iter.sv
// rtl/int_mul_iter.sv - iterative RV64M/RV32 multiplier, STEP_BITS multiplier bits per cycle.
// Optional behavioural result check: RIVER_INT_MUL_SELFCHECK_EN.
module int_mul_iter #(
  parameter int STEP_BITS = 4
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_ena,
  input  logic        i_unsigned,
  input  logic        i_hsu,
  input  logic        i_high,
  input  logic        i_rv32,
  input  logic [63:0] i_a1,
  input  logic [63:0] i_a2,
  output logic [63:0] o_res,
  output logic        o_valid,
  output logic        o_busy
);

  localparam int CW = $clog2(64 / STEP_BITS + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t         state;
  logic [127:0]   acc;
  logic [127:0]   mcand;
  logic [63:0]    mplier;
  logic [CW-1:0]  cnt;
  logic           high_q;
  logic           rv32_q;
  logic           neg_q;

  logic [63:0]    a1_ext, a2_ext, a1_mag, a2_mag;
  logic           a1_signed, a2_signed, a1_neg, a2_neg;
  logic [127:0]   prod;
  logic [63:0]    sel_res;

  // i_unsigned overrides i_hsu; MULHSU keeps only the multiplicand signed
  always_comb begin
    a1_ext    = i_rv32 ? {{32{i_a1[31]}}, i_a1[31:0]} : i_a1;
    a2_ext    = i_rv32 ? {{32{i_a2[31]}}, i_a2[31:0]} : i_a2;
    a1_signed = !i_unsigned;
    a2_signed = !i_unsigned && !i_hsu;
    a1_neg    = a1_signed && a1_ext[63];
    a2_neg    = a2_signed && a2_ext[63];
    a1_mag    = a1_neg ? (64'd0 - a1_ext) : a1_ext;
    a2_mag    = a2_neg ? (64'd0 - a2_ext) : a2_ext;
  end

  always_comb begin
    prod = neg_q ? (128'd0 - acc) : acc;
    if (rv32_q)
      sel_res = {{32{prod[31]}}, prod[31:0]};
    else if (high_q)
      sel_res = prod[127:64];
    else
      sel_res = prod[63:0];
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      high_q  <= 1'b0;
      rv32_q  <= 1'b0;
      neg_q   <= 1'b0;
      o_res   <= '0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_ena) begin
            state  <= RUN;
            o_busy <= 1'b1;
            high_q <= i_high;
            rv32_q <= i_rv32;
            neg_q  <= a1_neg ^ a2_neg;
            acc    <= '0;
            mcand  <= {64'd0, a1_mag};
            mplier <= a2_mag;
            cnt    <= i_rv32 ? CW'(32 / STEP_BITS) : CW'(64 / STEP_BITS);
          end
        end
        RUN: begin
          // multiplicand is pre-shifted so each digit lands at its own weight
          acc    <= acc + mcand * 128'(mplier[STEP_BITS-1:0]);
          mcand  <= mcand << STEP_BITS;
          mplier <= mplier >> STEP_BITS;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1))
            state <= FIN;
        end
        FIN: begin
          o_res   <= sel_res;
          o_valid <= 1'b1;
          o_busy  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RIVER_INT_MUL_SELFCHECK_EN
  logic [63:0] a1_dbg, a2_dbg, ref_res;
  logic [3:0]  mode_dbg;

  function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                          input logic uns, input logic hsu,
                                          input logic high, input logic rv32);
    logic signed [127:0] x, y, p;
    if (rv32) begin
      x = $signed({{96{a[31]}}, a[31:0]});
      y = $signed({{96{b[31]}}, b[31:0]});
      p = x * y;
      return {{32{p[31]}}, p[31:0]};
    end
    x = uns ? $signed({64'd0, a}) : $signed({{64{a[63]}}, a});
    y = (uns || hsu) ? $signed({64'd0, b}) : $signed({{64{b[63]}}, b});
    p = x * y;
    return high ? p[127:64] : p[63:0];
  endfunction

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      a1_dbg   <= '0;
      a2_dbg   <= '0;
      ref_res  <= '0;
      mode_dbg <= '0;
    end else if (state == IDLE && i_ena) begin
      a1_dbg   <= i_a1;
      a2_dbg   <= i_a2;
      mode_dbg <= {i_unsigned, i_hsu, i_high, i_rv32};
      ref_res  <= ref_mul(i_a1, i_a2, i_unsigned, i_hsu, i_high, i_rv32);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_nrst && state == FIN && sel_res != ref_res)
      $error("int_mul_iter: a1=%h a2=%h mode(uns,hsu,high,rv32)=%b exp=%h act=%h",
             a1_dbg, a2_dbg, mode_dbg, ref_res, sel_res);
  end
`endif

endmodule
